// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC and strobes PC changes to the memory block.
// Returned words are captured with their PC into a small FIFO that decode drains over valid/ready.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    localparam int         CW       = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          tb_loading,
    output logic [31:0]   mem_pc,
    output logic          mem_pc_changed,
    input  logic [31:0]   mem_data,
    input  logic          mem_stall,
    output logic          dec_valid,
    output logic [31:0]   dec_instr,
    output logic [31:0]   dec_pc,
    input  logic          dec_ready,
    output logic [CW-1:0] q_count,
    output logic          err_misalign
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_REDIR = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            pc_changed_q, pc_changed_d;
    logic            err_q, err_d;

    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     pc_q    [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic redir_take;
    logic full;
    logic pop;
    logic push;

    assign full       = (count_q == CW'(DEPTH));
    assign redir_take = redirect_valid && (state_q != ST_BOOT);
    assign dec_valid  = (count_q != '0) && !redirect_valid;
    assign pop        = dec_valid && dec_ready;
    // A full queue still accepts a word when the head leaves in the same cycle.
    assign push       = (state_q == ST_FETCH) && !redirect_valid && !tb_loading
                        && !mem_stall && (!full || pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = 1'b0;

        if (redir_take) begin
            state_d    = ST_REDIR;
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            err_d      = |redirect_pc[1:0];
        end else begin
            case (state_q)
                ST_BOOT:  state_d = tb_loading ? ST_LOAD : ST_FETCH;
                ST_FETCH: state_d = tb_loading ? ST_LOAD : ST_FETCH;
                ST_REDIR: state_d = tb_loading ? ST_LOAD : ST_FETCH;
                ST_LOAD:  state_d = tb_loading ? ST_LOAD : ST_BOOT;
                default:  state_d = ST_BOOT;
            endcase

            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        pc_changed_d = (state_d == ST_BOOT) || (state_d == ST_REDIR);
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q      <= ST_BOOT;
            fetch_pc_q   <= RESET_PC;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            pc_changed_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            pc_changed_q <= pc_changed_d;
            err_q        <= err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && (wr_ptr_q == AW'(gi));
        end
    endgenerate

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (RSTn && wr_en[i]) begin
                instr_q[i] <= mem_data;
                pc_q[i]    <= fetch_pc_q;
            end
        end
    end

    assign mem_pc         = fetch_pc_q;
    assign mem_pc_changed = pc_changed_q;
    assign dec_instr      = instr_q[rd_ptr_q];
    assign dec_pc         = pc_q[rd_ptr_q];
    assign q_count        = count_q;
    assign err_misalign   = err_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: boot fill, full-queue streaming, redirects, stalls, program load.
// The memory model returns a PC-tagged word so every dequeued instruction is checkable.
module tb_fetch_queue;

    localparam int CW = 3;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          tb_loading;
    logic [31:0]   mem_pc;
    logic          mem_pc_changed;
    logic [31:0]   mem_data;
    logic          mem_stall;
    logic          dec_valid;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc;
    logic          dec_ready;
    logic [CW-1:0] q_count;
    logic          err_misalign;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign mem_data = {8'hAB, mem_pc[23:0]};

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .tb_loading    (tb_loading),
        .mem_pc        (mem_pc),
        .mem_pc_changed(mem_pc_changed),
        .mem_data      (mem_data),
        .mem_stall     (mem_stall),
        .dec_valid     (dec_valid),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_ready     (dec_ready),
        .q_count       (q_count),
        .err_misalign  (err_misalign)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return {8'hAB, pc[23:0]};
    endfunction

    initial begin
        RSTn = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        tb_loading = 1'b0; mem_stall = 1'b0; dec_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_mem_pc", mem_pc, 32'h0);
        chk("rst_strobe", {31'b0, mem_pc_changed}, 32'h1);
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'h0);
        chk("rst_q_count", {29'b0, q_count}, 32'h0);
        chk("rst_err", {31'b0, err_misalign}, 32'h0);
        RSTn = 1'b1;

        // Boot cycle, then fill the queue with dec_ready low
        tick();
        chk("boot_strobe_off", {31'b0, mem_pc_changed}, 32'h0);
        chk("boot_no_push", {29'b0, q_count}, 32'h0);
        tick();
        chk("first_push_valid", {31'b0, dec_valid}, 32'h1);
        chk("first_push_count", {29'b0, q_count}, 32'h1);
        tick(); tick(); tick();
        tick();
        chk("full_count", {29'b0, q_count}, 32'h4);
        chk("full_mem_pc", mem_pc, 32'h10);
        chk("full_head_pc", dec_pc, 32'h0);

        // Drain while full: one word in, one word out every cycle
        dec_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("stream_pc[%0d]", i), dec_pc, 32'(i * 4));
            chk($sformatf("stream_instr[%0d]", i), dec_instr, tag_of(32'(i * 4)));
            chk($sformatf("stream_cnt[%0d]", i), {29'b0, q_count}, 32'h4);
            tick();
        end
        chk("stream_mem_pc", mem_pc, 32'h44);

        // Redirect while full with decode ready
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        chk("redir_blocks_pop", {31'b0, dec_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        chk("redir_count", {29'b0, q_count}, 32'h0);
        chk("redir_mem_pc", mem_pc, 32'h200);
        chk("redir_strobe", {31'b0, mem_pc_changed}, 32'h1);
        chk("redir_err", {31'b0, err_misalign}, 32'h0);
        tick();
        chk("redir_strobe_off", {31'b0, mem_pc_changed}, 32'h0);
        chk("redir_discard", {29'b0, q_count}, 32'h0);
        tick();
        chk("redir_first_pc", dec_pc, 32'h200);
        chk("redir_first_cnt", {29'b0, q_count}, 32'h1);

        // Stall toggling with decode always ready
        for (int k = 0; k < 4; k++) begin
            mem_stall = 1'b1;
            tick();
            chk($sformatf("stall_cnt[%0d]", k), {29'b0, q_count}, 32'h0);
            chk($sformatf("stall_mem_pc[%0d]", k), mem_pc, 32'h204 + 32'(k * 4));
            mem_stall = 1'b0;
            tick();
            chk($sformatf("go_cnt[%0d]", k), {29'b0, q_count}, 32'h1);
            chk($sformatf("go_pc[%0d]", k), dec_pc, 32'h204 + 32'(k * 4));
        end

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0106;
        tick();
        redirect_valid = 1'b0; dec_ready = 1'b0;
        chk("mis_mem_pc", mem_pc, 32'h104);
        chk("mis_err", {31'b0, err_misalign}, 32'h1);
        chk("mis_cnt", {29'b0, q_count}, 32'h0);
        tick();
        chk("mis_err_clear", {31'b0, err_misalign}, 32'h0);

        // Program load freezes fetch, then re-boots at the held PC
        tick(); tick();
        chk("preload_cnt", {29'b0, q_count}, 32'h2);
        tb_loading = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("load_cnt[%0d]", c), {29'b0, q_count}, 32'h2);
            chk($sformatf("load_pc[%0d]", c), mem_pc, 32'h10C);
        end
        tb_loading = 1'b0;
        tick();
        chk("reboot_strobe", {31'b0, mem_pc_changed}, 32'h1);
        tick();
        chk("reboot_strobe_off", {31'b0, mem_pc_changed}, 32'h0);
        chk("reboot_no_push", {29'b0, q_count}, 32'h2);
        tick();
        chk("resume_cnt", {29'b0, q_count}, 32'h3);
        chk("resume_mem_pc", mem_pc, 32'h110);
        dec_ready = 1'b1; mem_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("held_pc[%0d]", j), dec_pc, 32'h104 + 32'(j * 4));
            tick();
        end
        chk("drained", {31'b0, dec_valid}, 32'h0);

        // Reset mid-operation
        mem_stall = 1'b0;
        tick();
        RSTn = 1'b0;
        tick();
        chk("mid_rst_cnt", {29'b0, q_count}, 32'h0);
        chk("mid_rst_pc", mem_pc, 32'h0);
        chk("mid_rst_strobe", {31'b0, mem_pc_changed}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
